// File: rtl/edge_frame_gate.sv
// Single-frame capture gate: forwards exactly H_ACT*V_ACT pixels per capture, padding short frames.
// Optional macro EDGE_THRESH_EN binarises forwarded pixels against THRESH.
module edge_frame_gate #(
    parameter int          H_ACT  = 176,
    parameter int          V_ACT  = 240,
    parameter logic [7:0]  THRESH = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture_req,
    input  logic       tx_frame_done,
    input  logic       in_vsync,
    input  logic       in_de,
    input  logic [7:0] in_data,
    output logic       canny_de,
    output logic [7:0] canny_data,
    output logic       busy,
    output logic       frame_err
);

    localparam int             PIX  = H_ACT * V_ACT;
    localparam int             CW   = $clog2(PIX + 1);
    localparam logic [CW-1:0]  LAST = CW'(PIX);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, PAD, HOLD} state_t;

    state_t        state;
    logic          vsync_q;
    logic          vs_rise;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    pix;

    assign vs_rise = in_vsync & ~vsync_q;
    assign cnt_inc = cnt + CW'(1);

`ifdef EDGE_THRESH_EN
    assign pix = (in_data >= THRESH) ? 8'hFF : 8'h00;
`else
    logic thresh_unused;
    assign pix           = in_data;
    assign thresh_unused = ^THRESH;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            cnt        <= '0;
            canny_de   <= 1'b0;
            canny_data <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vsync_q    <= in_vsync;
            canny_de   <= 1'b0;
            canny_data <= '0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (capture_req) begin
                        state     <= ARM;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                ARM: begin
                    if (vs_rise) begin
                        state <= CAPTURE;
                        // A pixel coincident with the frame-start edge is the first pixel.
                        if (in_de) begin
                            canny_de   <= 1'b1;
                            canny_data <= pix;
                            cnt        <= cnt_inc;
                            if (cnt_inc == LAST) state <= HOLD;
                        end
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_err <= 1'b1;
                        state     <= PAD;
                    end else if (in_de) begin
                        canny_de   <= 1'b1;
                        canny_data <= pix;
                        cnt        <= cnt_inc;
                        if (cnt_inc == LAST) state <= HOLD;
                    end
                end
                PAD: begin
                    canny_de <= 1'b1;
                    cnt      <= cnt_inc;
                    if (cnt_inc == LAST) state <= HOLD;
                end
                HOLD: begin
                    if (tx_frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_frame_gate.sv
// Directed scenario sequence with random pixel data; expected output stream built from the
// frame rules (first LAST pixels, zero padding after a short frame) and compared with stamps.
module tb_edge_frame_gate;

    localparam int LAST = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       capture_req = 1'b0;
    logic       tx_frame_done = 1'b0;
    logic       in_vsync = 1'b0;
    logic       in_de = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       canny_de;
    logic [7:0] canny_data;
    logic       busy;
    logic       frame_err;

    edge_frame_gate #(.H_ACT(4), .V_ACT(2), .THRESH(8'd128)) dut (
        .clk(clk), .reset(reset), .capture_req(capture_req), .tx_frame_done(tx_frame_done),
        .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
        .canny_de(canny_de), .canny_data(canny_data), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [7:0] data;
    } ev_t;

    int  cyc = 0;
    int  passed = 0;
    int  failed = 0;
    int  total = 0;
    ev_t got_q[$];
    ev_t exp_q[$];
    ev_t in_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (canny_de === 1'b1) begin
            ev_t e;
            e.stamp = cyc;
            e.data  = canny_data;
            got_q.push_back(e);
        end
    end

    function automatic logic [7:0] xf(input logic [7:0] d);
`ifdef EDGE_THRESH_EN
        return (d >= 8'd128) ? 8'hFF : 8'h00;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic de, input logic [7:0] d,
                         input logic cap, input logic tfd, input bit count_pix);
        in_vsync      = vs;
        in_de         = de;
        in_data       = d;
        capture_req   = cap;
        tx_frame_done = tfd;
        if (count_pix) begin
            ev_t e;
            e.stamp = cyc;
            e.data  = d;
            in_q.push_back(e);
        end
        tick();
        in_de         = 1'b0;
        capture_req   = 1'b0;
        tx_frame_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            drive(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Output stream = first LAST frame pixels one cycle later, then zero pads from vs_cyc+2.
    task automatic build_expected(input bit short_term, input int vs_cyc);
        int n = in_q.size();
        int k = (n < LAST) ? n : LAST;
        for (int i = 0; i < k; i++) begin
            ev_t e;
            e.stamp = in_q[i].stamp + 1;
            e.data  = xf(in_q[i].data);
            exp_q.push_back(e);
        end
        if (short_term) begin
            for (int j = 0; j < LAST - n; j++) begin
                ev_t e;
                e.stamp = vs_cyc + 2 + j;
                e.data  = 8'h00;
                exp_q.push_back(e);
            end
        end
        in_q.delete();
    endtask

    task automatic check_stream(input string tag);
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cycle%0d", tag, i), got_q[i].stamp, exp_q[i].stamp);
            chk($sformatf("%s_data%0d", tag, i), int'(got_q[i].data), int'(exp_q[i].data));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_capture(input string tag);
        chk({tag, "_busy_before"}, busy, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk({tag, "_busy_after_req"}, busy, 1);
    endtask

    task automatic finish_tx(input string tag);
        chk({tag, "_busy_hold"}, busy, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk({tag, "_busy_after_done"}, busy, 0);
    endtask

    int v;

    initial begin
        tick();
        tick();
        chk("rst_de", canny_de, 0);
        chk("rst_data", int'(canny_data), 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        reset = 1'b0;
        idle(2);
        got_q.delete();

        // Nominal frame, back-to-back pixels 0x10..0x80
        start_capture("nom");
        chk("nom_err", frame_err, 0);
        idle(2);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LAST; i++) drive(1'b0, 1'b1, 8'(16 * (i + 1)), 1'b0, 1'b0, 1'b1);
        idle(3);
        build_expected(1'b0, 0);
        check_stream("nom");
        chk("nom_err_end", frame_err, 0);
        finish_tx("nom");

        // Short frame: 5 pixels then a new frame start (its pixel is dropped)
        idle(1);
        start_capture("short");
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rand_pixels(5);
        chk("short_err_pre", frame_err, 0);
        v = cyc;
        drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("short_err_set", frame_err, 1);
        idle(6);
        build_expected(1'b1, v);
        check_stream("short");
        finish_tx("short");
        chk("short_err_sticky", frame_err, 1);

        // Long frame; capture_req and tx_frame_done during capture are ignored
        start_capture("long");
        chk("long_err_cleared", frame_err, 0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rand_pixels(2);
        drive(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
        rand_pixels(1);
        drive(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b1);
        rand_pixels(6);
        idle(3);
        build_expected(1'b0, 0);
        check_stream("long");
        chk("long_err", frame_err, 0);
        finish_tx("long");
        idle(2);
        chk("long_no_rearm", busy, 0);

        // Coincident edge: pixel before the edge dropped, pixel on the edge is pixel 1
        start_capture("coin");
        drive(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        rand_pixels(LAST - 1);
        idle(3);
        build_expected(1'b0, 0);
        check_stream("coin");
        finish_tx("coin");

        // Reset after 3 pixels, then a clean full capture
        start_capture("rst");
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rand_pixels(2);
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_de_pre", canny_de, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_de", canny_de, 0);
        chk("rst_mid_data", int'(canny_data), 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", frame_err, 0);
        // Third pixel is cleared before the monitor's sampling edge
        void'(in_q.pop_back());
        build_expected(1'b0, 0);
        check_stream("rst_partial");
        tick();
        reset = 1'b0;
        idle(2);
        start_capture("after_rst");
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rand_pixels(LAST + 2);
        idle(3);
        build_expected(1'b0, 0);
        check_stream("after_rst");
        chk("after_rst_err", frame_err, 0);
        finish_tx("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
